// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter sequencer: op codes, FSM states, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

  // Width of the shared combinational shifter; ROR/SRA second-pass amounts are relative to it.
  localparam int SHIFTER_W   = 24;
  localparam int DATA_W_DEF  = SHIFTER_W;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // SRA and ROR are synthesised from two logical passes; SRL/SLL need only one.
  function automatic logic two_pass(input op_e op);
    return (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Bundles requester, response and shifter-side signals of the shift sequencer.
// Latency: n/a (wiring only).
// Backpressure: req valid/ready per requester, resp valid/ready to the consumer.
interface shift_ctrl_if
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int NREQ    = 2,
  parameter int ID_W    = 1
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [2*NREQ-1:0]       req_op;
  logic [DATA_W*NREQ-1:0]  req_a;
  logic [SHAMT_W*NREQ-1:0] req_b;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_W-1:0]       resp_data;
  logic [ID_W-1:0]         resp_id;
  logic [DATA_W-1:0]       sh_a;
  logic [SHAMT_W-1:0]      sh_b;
  logic                    sh_funct;
  logic [DATA_W-1:0]       sh_res;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, sh_res,
    output req_ready, resp_valid, resp_data, resp_id, sh_a, sh_b, sh_funct
  );

  // Requesters, consumer and shifter side.
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, sh_res,
    input  req_ready, resp_valid, resp_data, resp_id, sh_a, sh_b, sh_funct
  );

endinterface

// File: rtl/shift_rr_arb.sv
// Round-robin arbiter: searches upward from ptr (wrapping) for the first active request.
// Latency: combinational.
// Backpressure: no grant while en is low; winner is valid whenever any req is set.
module shift_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] winner
);

  logic found;
  int   idx;

  // Rotating priority search starting at ptr; grant is gated by en.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    grant  = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    if (en && found) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/shift_ctrl.sv
// Arbitrates shift requests and sequences the shared logical shifter over one or two passes.
// Latency: handshake to resp_valid 2 cycles (SRL/SLL) or 3 cycles (SRA/ROR).
// Backpressure: one op in flight; req_ready only in IDLE, result held until resp_ready.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int NREQ    = 2,
  parameter int ID_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  shift_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  op_e                 op_q, op_w;
  logic [DATA_W-1:0]   a_q, acc_q, a_w;
  logic [SHAMT_W-1:0]  amt_q, b_w, eff_b_w;
  logic [ID_W-1:0]     id_q, ptr_q, winner;
  logic [NREQ-1:0]     grant;
  logic                arb_en, hs;
  logic [DATA_W-1:0]   sh_a;
  logic [SHAMT_W-1:0]  sh_b;
  logic                sh_funct;

  // Reset also masks grants so nothing is offered while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  shift_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .grant  (grant),
    .winner (winner)
  );

  assign bus.req_ready = grant;
  assign hs            = |grant;

  // Select the winner's request fields and fold the amount into the range each op needs.
  always_comb begin
    op_w    = op_e'(bus.req_op[2*int'(winner) +: 2]);
    a_w     = bus.req_a[DATA_W*int'(winner) +: DATA_W];
    b_w     = bus.req_b[SHAMT_W*int'(winner) +: SHAMT_W];
    eff_b_w = b_w;
    if (op_w == OP_SRA && b_w > SHAMT_W'(DATA_W-1))
      eff_b_w = SHAMT_W'(DATA_W-1);
    else if (op_w == OP_ROR && b_w >= SHAMT_W'(DATA_W))
      eff_b_w = b_w - SHAMT_W'(DATA_W);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and shifter drive; shifter inputs are parked at 0 outside the pass states.
  always_comb begin
    state_d  = state_q;
    sh_a     = '0;
    sh_b     = '0;
    sh_funct = 1'b0;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_PASS1;
      ST_PASS1: begin
        sh_a     = a_q;
        sh_b     = amt_q;
        sh_funct = (op_q == OP_SLL);
        state_d  = two_pass(op_q) ? ST_PASS2 : ST_DONE;
      end
      ST_PASS2: begin
        // Left shift by (W - amt) supplies the sign fill (SRA) or wrapped bits (ROR); amt=0 gives 0.
        sh_a     = (op_q == OP_SRA) ? {DATA_W{a_q[DATA_W-1]}} : a_q;
        sh_b     = SHAMT_W'(DATA_W) - amt_q;
        sh_funct = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, round-robin pointer and result accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_SRL;
      a_q   <= '0;
      amt_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
      acc_q <= '0;
    end else begin
      if (hs) begin
        op_q  <= op_w;
        a_q   <= a_w;
        amt_q <= eff_b_w;
        id_q  <= winner;
        ptr_q <= (winner == ID_W'(NREQ-1)) ? '0 : ID_W'(winner + 1'b1);
      end
      if (state_q == ST_PASS1) acc_q <= bus.sh_res;
      if (state_q == ST_PASS2) acc_q <= acc_q | bus.sh_res;
    end
  end

  assign bus.sh_a       = sh_a;
  assign bus.sh_b       = sh_b;
  assign bus.sh_funct   = sh_funct;
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_data  = acc_q;
  assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl with a behavioural shifter and a response scoreboard.
// Latency: checks 2/3-cycle handshake-to-valid latency per op.
// Backpressure: exercises held results under resp_ready=0 and competing requesters.
module tb_shift_ctrl;

  localparam int DW = 24;
  localparam int SW = 5;

  logic clk;
  logic rst;
  logic [1:0]    req_valid;
  logic [1:0]    op_t [2];
  logic [DW-1:0] a_t  [2];
  logic [SW-1:0] b_t  [2];
  logic          resp_ready;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  int nhs  = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            lat;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  logic resp_seen;

  shift_ctrl_if #(.DATA_W(DW), .SHAMT_W(SW), .NREQ(2), .ID_W(1)) bus ();

  shift_ctrl #(.DATA_W(DW), .SHAMT_W(SW), .NREQ(2), .ID_W(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.req_valid  = req_valid;
  assign bus.req_op     = {op_t[1], op_t[0]};
  assign bus.req_a      = {a_t[1], a_t[0]};
  assign bus.req_b      = {b_t[1], b_t[0]};
  assign bus.resp_ready = resp_ready;
  // The shared logical shifter that normally lives in the parent.
  assign bus.sh_res     = bus.sh_funct ? (bus.sh_a << bus.sh_b) : (bus.sh_a >> bus.sh_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_shift(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [SW-1:0] b);
    int r;
    logic [DW-1:0] res;
    r = int'(b) % DW;
    case (op)
      2'b00:   res = a >> b;
      2'b01:   res = a << b;
      2'b10:   res = DW'($signed(a) >>> b);
      default: res = (a >> r) | (a << (DW - r));
    endcase
    return res;
  endfunction

  // Scoreboard: push on request handshake, compare on response handshake.
  initial begin
    resp_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        resp_seen = 1'b0;
      end else begin
        if (|bus.req_ready)
          check("ready_onehot", $countones(bus.req_ready), 1);
        for (int r = 0; r < 2; r++) begin
          if (req_valid[r] && bus.req_ready[r]) begin
            sb.push_back('{id: r, data: ref_shift(op_t[r], a_t[r], b_t[r]),
                           lat: op_t[r][1] ? 3 : 2, cyc: cyc});
            gnt_log.push_back(r);
            nhs++;
          end
        end
        if (bus.resp_valid && !resp_seen) begin
          resp_seen = 1'b1;
          check("resp_has_owner", sb.size() != 0, 1);
          if (sb.size() != 0) check("latency", cyc - sb[0].cyc, sb[0].lat);
        end
        if (bus.resp_valid && resp_ready && sb.size() != 0) begin
          check("resp_data", bus.resp_data, sb[0].data);
          check("resp_id", bus.resp_id, sb[0].id);
          void'(sb.pop_front());
          resp_seen = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input int r, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [SW-1:0] b);
    int n = 0;
    @(posedge clk); #1;
    op_t[r] = op; a_t[r] = a; b_t[r] = b; req_valid[r] = 1'b1;
    #1;
    while (!bus.req_ready[r] && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("grant_wait", n < 60, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    // Scramble inputs to show the in-flight op used the captured values.
    a_t[r] = ~a; b_t[r] = ~b; op_t[r] = ~op;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 60) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !bus.resp_valid) break;
      n++;
    end
    check("drain_wait", n < 60, 1);
  endtask

  task automatic wait_grants(input int target);
    int n = 0;
    while (gnt_log.size() < target && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("grant_count_wait", gnt_log.size() >= target, 1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin op_t[i] = 2'b00; a_t[i] = '0; b_t[i] = '0; end

    // Reset state, with requests present so req_ready masking is meaningful.
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_sh_a", bus.sh_a, 0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors.
    do_req(0, 2'b00, 24'h800000, 5'd4);
    do_req(1, 2'b10, 24'hF00000, 5'd4);
    do_req(1, 2'b10, 24'h800000, 5'd30);
    do_req(1, 2'b10, 24'h400000, 5'd4);
    do_req(0, 2'b11, 24'h000001, 5'd1);
    do_req(1, 2'b11, 24'h000001, 5'd25);
    do_req(0, 2'b11, 24'h000001, 5'd0);
    do_req(0, 2'b01, 24'h00ABCD, 5'd24);
    do_req(1, 2'b01, 24'h00ABCD, 5'd23);
    for (int i = 0; i < 10; i++)
      do_req(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DW'($urandom),
             SW'($urandom_range(0, 31)));
    drain();

    // Result held under backpressure while another requester waits.
    resp_ready = 1'b0;
    do_req(0, 2'b01, 24'h00ABCD, 5'd8);
    op_t[1] = 2'b00; a_t[1] = 24'h111111; b_t[1] = 5'd1; req_valid[1] = 1'b1;
    n0 = 0;
    while (!bus.resp_valid && n0 < 20) begin
      @(posedge clk); #2;
      n0++;
    end
    check("hold_resp_wait", n0 < 20, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("hold_valid", bus.resp_valid, 1);
      check("hold_data", bus.resp_data, 24'hABCD00);
      check("hold_id", bus.resp_id, 0);
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_sh_a", bus.sh_a, 0);
    end
    resp_ready = 1'b1; req_valid[1] = 1'b0;
    drain();

    // Alternating grants from a fresh reset with both requesters held.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n0 = gnt_log.size();
    op_t[0] = 2'b00; a_t[0] = 24'h123456; b_t[0] = 5'd4;
    op_t[1] = 2'b11; a_t[1] = 24'h00F00F; b_t[1] = 5'd8;
    req_valid = 2'b11;
    wait_grants(n0 + 4);
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++)
      if (gnt_log.size() > n0 + i) check("rr_order", gnt_log[n0+i], i % 2);
    drain();

    // Reset in the middle of a two-pass op.
    do_req(1, 2'b11, 24'h000001, 5'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_resp_data", bus.resp_data, 0);
    @(posedge clk); #1; req_valid = 2'b00;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("no_stale_resp", bus.resp_valid, 0);
    end
    n0 = gnt_log.size();
    op_t[0] = 2'b00; a_t[0] = 24'h00FF00; b_t[0] = 5'd8;
    op_t[1] = 2'b01; a_t[1] = 24'h00FF00; b_t[1] = 5'd8;
    @(posedge clk); #1; req_valid = 2'b11;
    wait_grants(n0 + 1);
    req_valid = 2'b00;
    if (gnt_log.size() > n0) check("first_grant_after_rst", gnt_log[n0], 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
